// File: rtl/bnn_vad_pkg.sv
// Shared constants for the BNN VAD datapath: activation geometry and
// the MAC feeder state encoding.
package bnn_vad_pkg;

  localparam int ELEM_W  = 3;
  localparam int N_ELEM  = 36;
  localparam int FRAME_W = ELEM_W * N_ELEM;
  localparam int IDX_W   = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } feed_state_e;

endpackage

// File: rtl/mac_feeder.sv
// Serialises packed activation frames into the MAC one element per cycle,
// MSB-first, with a one-deep pending buffer for back-to-back frames.
module mac_feeder
  import bnn_vad_pkg::*;
#(
  parameter int DONE_TO = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               pause,
  output logic [ELEM_W-1:0]  mac_in,
  output logic               mac_in_valid,
  output logic               mac_first,
  output logic               mac_last,
  input  logic               mac_done,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic               err
);

  localparam int TMR_W = (DONE_TO > 1) ? $clog2(DONE_TO) : 1;

  feed_state_e        state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [FRAME_W-1:0] pend_q, pend_d;
  logic               pend_full_q, pend_full_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [ELEM_W-1:0]  mac_in_q, mac_in_d;
  logic               vld_q, vld_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               load, accept;

  assign frame_ready = !pend_full_q;
  assign accept      = frame_valid && !pend_full_q;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    mac_in_d    = mac_in_q;
    vld_d       = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    cnt_d       = cnt_q;
    err_d       = err_q;
    load        = 1'b0;

    case (state_q)
      IDLE: load = pend_full_q;
      STREAM: begin
        if (idx_q == IDX_W'(N_ELEM)) begin
          state_d = WAIT_DONE;
          tmr_d   = '0;
        end else if (!pause) begin
          mac_in_d = sr_q[FRAME_W-1 -: ELEM_W];
          sr_d     = sr_q << ELEM_W;
          idx_d    = idx_q + 1'b1;
          vld_d    = 1'b1;
          last_d   = (idx_q == IDX_W'(N_ELEM - 1));
        end
      end
      WAIT_DONE: begin
        // mac_done wins over a timeout landing on the same edge
        if (mac_done) begin
          cnt_d = cnt_q + 1'b1;
          if (pend_full_q) load = 1'b1;
          else             state_d = IDLE;
        end else if (tmr_q == TMR_W'(DONE_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      mac_in_d    = pend_q[FRAME_W-1 -: ELEM_W];
      sr_d        = pend_q << ELEM_W;
      idx_d       = IDX_W'(1);
      vld_d       = 1'b1;
      first_d     = 1'b1;
      pend_full_d = 1'b0;
      state_d     = STREAM;
    end

    // accept after load so a same-edge refill leaves the buffer full
    if (accept) begin
      pend_d      = frame_in;
      pend_full_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      tmr_q       <= '0;
      mac_in_q    <= '0;
      vld_q       <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      mac_in_q    <= mac_in_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign mac_in       = mac_in_q;
  assign mac_in_valid = vld_q;
  assign mac_first    = first_q;
  assign mac_last     = last_q;
  assign busy         = busy_q;
  assign frame_cnt    = cnt_q;
  assign err          = err_q;

endmodule
